imm_encoder: RTL

//  Inverse of the decode-side immediate generator: packs operand fields plus a 32-bit signed

---
 rtl/imm_encoder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// RV32I instruction packer: combinational field/immediate encoding with range checks,
// streamed through a 2-entry output FIFO with a per-word byte address.
module imm_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic              err_sticky_o
);

    localparam logic [2:0]  FMT_R     = 3'd0;
    localparam logic [2:0]  FMT_I     = 3'd1;
    localparam logic [2:0]  FMT_SHIFT = 3'd2;
    localparam logic [2:0]  FMT_S     = 3'd3;
    localparam logic [2:0]  FMT_B     = 3'd4;
    localparam logic [2:0]  FMT_J     = 3'd5;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic [31:0]       enc_word;
    logic              enc_err;

    logic [31:0]       buf_instr [2];
    logic [ADDR_W-1:0] buf_addr  [2];
    logic              buf_err   [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [ADDR_W-1:0] addr_cnt;
    logic              sticky;
    logic              push;
    logic              pop;

    // Range checks are sign-extension tests: all bits above the field's sign bit must match it.
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
        case (fmt_i)
            FMT_R: begin
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = 1'b0;
            end
            FMT_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
            end
            FMT_SHIFT: begin
                enc_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = |imm_i[31:5];
            end
            FMT_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
            end
            FMT_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
            end
            FMT_J: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_err  = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    // clear_i suppresses both handshakes so a flush never races a same-cycle push or pop.
    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);
    assign push    = valid_i && ready_o && !clear_i;
    assign pop     = valid_o && ready_i && !clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_addr[0]  <= BASE_ADDR;
            buf_addr[1]  <= BASE_ADDR;
            buf_err[0]   <= 1'b0;
            buf_err[1]   <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
            addr_cnt     <= BASE_ADDR;
            sticky       <= 1'b0;
        end else if (clear_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            sticky   <= 1'b0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= enc_word;
                buf_addr[wr_ptr]  <= addr_cnt;
                buf_err[wr_ptr]   <= enc_err;
                wr_ptr            <= ~wr_ptr;
                addr_cnt          <= addr_cnt + ADDR_W'(4);
                if (enc_err) begin
                    sticky <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign instr_o      = buf_instr[rd_ptr];
    assign addr_o       = buf_addr[rd_ptr];
    assign err_o        = buf_err[rd_ptr];
    assign err_sticky_o = sticky;

endmodule
